parking_gate_arbiter: RTL

PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

---
 rtl/parking_pkg.sv | 13 +
 rtl/rr_pick2.sv | 15 +
 rtl/parking_gate_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate arbiter.
package parking_pkg;
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ISSUE_EXIT  = 3'd1,
    ST_ISSUE_ENTRY = 3'd2,
    ST_ISSUE_DENY  = 3'd3,
    ST_SETTLE      = 3'd4
  } state_e;

  localparam int GATE_W                  = 1;
  localparam int MAX_EXIT_STREAK_DEFAULT = 4;
endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin pick: the pointer names the gate with priority this round.
module rr_pick2
  import parking_pkg::*;
(
  input  logic [1:0]        req_i,
  input  logic [GATE_W-1:0] ptr_i,
  output logic              valid_o,
  output logic [GATE_W-1:0] idx_o
);
  always_comb begin
    valid_o = |req_i;
    if (req_i[ptr_i]) idx_o = ptr_i;
    else              idx_o = ~ptr_i;
  end
endmodule

// File: rtl/parking_gate_arbiter.sv
// Arbitrates entry/exit gate requests into one-at-a-time registered commands
// for the parking controller, with exit-streak fairness and deny counting.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 1,
  parameter int MAX_EXIT_STREAK = MAX_EXIT_STREAK_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] entry_req,
  input  logic [1:0] entry_is_uni,
  input  logic [1:0] exit_req,
  input  logic [1:0] exit_is_uni,
  input  logic       is_uni_vacated_space,
  input  logic       is_vacated_space,
  output logic [1:0] entry_ack,
  output logic [1:0] entry_deny,
  output logic [1:0] exit_ack,
  output logic       car_entered,
  output logic       is_uni_car_entered,
  output logic       car_exited,
  output logic       is_uni_car_exited,
  output logic       busy,
  output logic [7:0] deny_count,
  output logic [2:0] state_dbg
);
  localparam logic [7:0] STREAK_MAX  = 8'(MAX_EXIT_STREAK);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_e            state_q;
  logic [GATE_W-1:0] entry_ptr_q, exit_ptr_q;
  logic [7:0]        streak_q, settle_q, deny_count_q;
  logic [1:0]        entry_ack_q, entry_deny_q, exit_ack_q;
  logic              car_entered_q, uni_in_q, car_exited_q, uni_out_q, busy_q;

  logic              entry_v, exit_v, take_exit_d, space_ok_d;
  logic [GATE_W-1:0] entry_idx, exit_idx;

  rr_pick2 u_entry_pick (
    .req_i  (entry_req),
    .ptr_i  (entry_ptr_q),
    .valid_o(entry_v),
    .idx_o  (entry_idx)
  );

  rr_pick2 u_exit_pick (
    .req_i  (exit_req),
    .ptr_i  (exit_ptr_q),
    .valid_o(exit_v),
    .idx_o  (exit_idx)
  );

  // Exits win unless they have starved a waiting entry for MAX_EXIT_STREAK grants.
  always_comb begin
    take_exit_d = exit_v && !((streak_q >= STREAK_MAX) && entry_v);
    space_ok_d  = entry_is_uni[entry_idx] ? is_uni_vacated_space : is_vacated_space;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      entry_ptr_q   <= '0;
      exit_ptr_q    <= '0;
      streak_q      <= '0;
      settle_q      <= '0;
      deny_count_q  <= '0;
      entry_ack_q   <= '0;
      entry_deny_q  <= '0;
      exit_ack_q    <= '0;
      car_entered_q <= 1'b0;
      uni_in_q      <= 1'b0;
      car_exited_q  <= 1'b0;
      uni_out_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      entry_ack_q   <= '0;
      entry_deny_q  <= '0;
      exit_ack_q    <= '0;
      car_entered_q <= 1'b0;
      uni_in_q      <= 1'b0;
      car_exited_q  <= 1'b0;
      uni_out_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (take_exit_d) begin
            state_q              <= ST_ISSUE_EXIT;
            busy_q               <= 1'b1;
            exit_ack_q[exit_idx] <= 1'b1;
            car_exited_q         <= 1'b1;
            uni_out_q            <= exit_is_uni[exit_idx];
            exit_ptr_q           <= ~exit_idx;
            if (streak_q < STREAK_MAX) streak_q <= streak_q + 8'd1;
          end else if (entry_v) begin
            busy_q      <= 1'b1;
            entry_ptr_q <= ~entry_idx;
            streak_q    <= '0;
            if (space_ok_d) begin
              state_q                <= ST_ISSUE_ENTRY;
              entry_ack_q[entry_idx] <= 1'b1;
              car_entered_q          <= 1'b1;
              uni_in_q               <= entry_is_uni[entry_idx];
            end else begin
              state_q                 <= ST_ISSUE_DENY;
              entry_deny_q[entry_idx] <= 1'b1;
              if (deny_count_q != 8'hFF) deny_count_q <= deny_count_q + 8'd1;
            end
          end
        end
        ST_ISSUE_EXIT, ST_ISSUE_ENTRY, ST_ISSUE_DENY: begin
          settle_q <= '0;
          if (SETTLE_CYCLES == 0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            settle_q <= settle_q + 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign entry_ack          = entry_ack_q;
  assign entry_deny         = entry_deny_q;
  assign exit_ack           = exit_ack_q;
  assign car_entered        = car_entered_q;
  assign is_uni_car_entered = uni_in_q;
  assign car_exited         = car_exited_q;
  assign is_uni_car_exited  = uni_out_q;
  assign busy               = busy_q;
  assign deny_count         = deny_count_q;
  assign state_dbg          = state_q;
endmodule
